// File: rtl/counter_arbiter.sv
// counter_arbiter: two requesters share one up-counter under round-robin
// arbitration. A granted requester owns the counter until it reaches the
// length latched at grant time (then a one-cycle done pulse) or until it
// drops its request (abort, no done pulse).
//
// Ports:
//   clk         - clock, all state updates on rising edge
//   reset       - asynchronous active-low reset
//   req0/req1   - level requests, held until done or abort
//   len0/len1   - terminal counts, sampled only at grant
//   gnt0/gnt1   - registered grants, high while that requester owns the counter
//   done0/done1 - registered one-cycle completion pulses
//   out         - shared counter value (0 outside RUN)
//   busy        - high whenever the arbiter is not IDLE
module counter_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             owner, owner_next;
  logic             ptr, ptr_next;
  logic [WIDTH-1:0] len_q, len_next;
  logic [WIDTH-1:0] out_next;
  logic             gnt0_next, gnt1_next;
  logic             done0_next, done1_next;
  logic             busy_next;
  logic             owner_req;
  logic             pick;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
      ptr   <= 1'b0;
      len_q <= '0;
      out   <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      ptr   <= ptr_next;
      len_q <= len_next;
      out   <= out_next;
      gnt0  <= gnt0_next;
      gnt1  <= gnt1_next;
      done0 <= done0_next;
      done1 <= done1_next;
      busy  <= busy_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next = state;
    owner_next = owner;
    ptr_next   = ptr;
    len_next   = len_q;
    out_next   = out;
    gnt0_next  = gnt0;
    gnt1_next  = gnt1;
    done0_next = 1'b0;
    done1_next = 1'b0;
    pick       = 1'b0;
    owner_req  = owner ? req1 : req0;

    case (state)
      IDLE: begin
        out_next  = '0;
        gnt0_next = 1'b0;
        gnt1_next = 1'b0;
        if (req0 || req1) begin
          // Pointer breaks ties; a lone requester wins outright
          pick       = (req0 && req1) ? ptr : req1;
          owner_next = pick;
          ptr_next   = ~pick;
          len_next   = pick ? len1 : len0;
          gnt0_next  = ~pick;
          gnt1_next  = pick;
          state_next = RUN;
        end
      end
      RUN: begin
        if (!owner_req) begin
          // Abort wins even at the terminal count
          state_next = IDLE;
          gnt0_next  = 1'b0;
          gnt1_next  = 1'b0;
          out_next   = '0;
        end else if (out == len_q) begin
          state_next = DONE;
          gnt0_next  = 1'b0;
          gnt1_next  = 1'b0;
          done0_next = ~owner;
          done1_next = owner;
          out_next   = '0;
        end else begin
          out_next = out + WIDTH'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        gnt0_next  = 1'b0;
        gnt1_next  = 1'b0;
        out_next   = '0;
      end
      default: begin
        state_next = IDLE;
        gnt0_next  = 1'b0;
        gnt1_next  = 1'b0;
        out_next   = '0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with hand-computed expectations.
module tb_counter_arbiter;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             req0, req1;
  logic [WIDTH-1:0] len0, len1;
  logic             gnt0, gnt1, done0, done1, busy;
  logic [WIDTH-1:0] out;

  int checks = 0;
  int errors = 0;

  counter_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .len0  (len0),
    .len1  (len1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .out   (out),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge, sample 1 time unit later, check exclusivity invariants
  task automatic tick();
    @(posedge clk);
    #1;
    check("gnt_mutex", 32'(gnt0 & gnt1), 32'd0);
    check("done_mutex", 32'(done0 & done1), 32'd0);
  endtask

  task automatic expect_all(input string tag, input logic g0, input logic g1,
                            input logic d0, input logic d1,
                            input logic [WIDTH-1:0] o, input logic b);
    check({tag, "_gnt0"}, 32'(gnt0), 32'(g0));
    check({tag, "_gnt1"}, 32'(gnt1), 32'(g1));
    check({tag, "_done0"}, 32'(done0), 32'(d0));
    check({tag, "_done1"}, 32'(done1), 32'(d1));
    check({tag, "_out"}, 32'(out), 32'(o));
    check({tag, "_busy"}, 32'(busy), 32'(b));
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    expect_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    len0  = '0;
    len1  = '0;
    #1;
    expect_all("por", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Single request, len0=3: four grant cycles, done, then idle
    req0 = 1'b1; len0 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_all("single_run", 1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(i), 1'b1);
    end
    tick();
    expect_all("single_done", 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    req0 = 1'b0;
    tick();
    expect_all("single_idle", 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Contention out of reset: requester 0 first, then 1
    do_reset();
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd1; len1 = 4'd1;
    tick(); expect_all("cont_g0a", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    tick(); expect_all("cont_g0b", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1);
    tick(); expect_all("cont_d0", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    req0 = 1'b0;
    tick(); expect_all("cont_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(); expect_all("cont_g1a", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    tick(); expect_all("cont_g1b", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1);
    tick(); expect_all("cont_d1", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
    req1 = 1'b0;
    tick(); expect_all("cont_end", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Round-robin with both held: 0,1,0,1 (pointer is back at 0 here)
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd0; len1 = 4'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_gnt0", 32'(gnt0), 32'((k % 2) == 0));
      check("rr_gnt1", 32'(gnt1), 32'((k % 2) == 1));
      tick();
      check("rr_done0", 32'(done0), 32'((k % 2) == 0));
      check("rr_done1", 32'(done1), 32'((k % 2) == 1));
      tick();
      check("rr_idle", 32'(busy), 32'd0);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Boundary len0=0: one-cycle grant
    req0 = 1'b1; len0 = 4'd0;
    tick(); expect_all("len0_run", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    tick(); expect_all("len0_done", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    req0 = 1'b0;
    tick();

    // Boundary len0=15: counts 0..15, no wrap within the grant
    req0 = 1'b1; len0 = 4'd15;
    for (int i = 0; i < 16; i++) begin
      tick();
      expect_all("max_run", 1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(i), 1'b1);
    end
    tick(); expect_all("max_done", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    req0 = 1'b0;
    tick();

    // Abort at out=2 with len0=5; len0 and req1 changes ignored mid-run
    req0 = 1'b1; len0 = 4'd5;
    tick();
    len0 = 4'd1; req1 = 1'b1;
    tick(); expect_all("ign_run1", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1);
    tick(); expect_all("ign_run2", 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1);
    req1 = 1'b0;
    req0 = 1'b0;
    tick(); expect_all("abort_mid", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(); expect_all("abort_mid2", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Abort at the terminal count: no done pulse
    req0 = 1'b1; len0 = 4'd5;
    for (int i = 0; i < 6; i++) tick();
    check("abort_end_out", 32'(out), 32'd5);
    req0 = 1'b0;
    tick(); expect_all("abort_end", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick(); expect_all("abort_end2", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Async reset between edges at out=2, then req1 granted right after release
    req0 = 1'b1; len0 = 4'd5;
    for (int i = 0; i < 3; i++) tick();
    check("pre_rst_out", 32'(out), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    expect_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req1 = 1'b1; len1 = 4'd2;
    tick(); expect_all("post_rst_g1", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    tick(); expect_all("post_rst_run", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1);
    req1 = 1'b0;
    tick(); expect_all("post_rst_abort", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
